// File: rtl/led_event_blinker.sv
// led_event_blinker
//    Turns single-cycle event strobes from core logic into human-visible LED
//    blinks. Each accepted event produces exactly one blink: a fixed on-time
//    followed by a fixed off-gap. Events that arrive mid-blink are queued in a
//    saturating counter and replayed one at a time.
//
//    state | meaning
//    ------+------------------------------------------------------------
//    IDLE  | no blink in progress, LED off, waiting for event_in
//    ON    | LED lit for 2**ON_BITS cycles
//    OFF   | LED dark for 2**OFF_BITS cycles, then replay a queued event
//
// Ports
//    clk       in   system clock, posedge
//    n_reset   in   synchronous active-low reset
//    event_in  in   event strobe, one event per high cycle
//    led_out   out  LED drive, active-high, registered
//    busy      out  high while a blink (on or gap) is in progress
//    pending   out  queued events not yet started
//    overflow  out  sticky, set when an event is dropped at saturation
module led_event_blinker #(
   parameter int ON_BITS  = 23,
   parameter int OFF_BITS = 23,
   parameter int PEND_W   = 4
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              event_in,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int CNT_W = (ON_BITS > OFF_BITS) ? ON_BITS : OFF_BITS;
   localparam logic [CNT_W-1:0]  ON_TC    = CNT_W'((2 ** ON_BITS) - 1);
   localparam logic [CNT_W-1:0]  OFF_TC   = CNT_W'((2 ** OFF_BITS) - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_d;
   logic              ovf_d;
   logic              off_term;

   assign off_term = (state_q == S_OFF) && (cnt_q == OFF_TC);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      pend_d  = pending;
      ovf_d   = overflow;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (event_in) state_d = S_ON;
         end
         S_ON: begin
            if (cnt_q == ON_TC) begin
               state_d = S_OFF;
               cnt_d   = '0;
            end
         end
         S_OFF: begin
            if (off_term) begin
               cnt_d = '0;
               if (pending != '0) begin
                  state_d = S_ON;
                  // a coincident event takes the slot just freed
                  if (!event_in) pend_d = pending - PEND_W'(1);
               end else if (event_in) begin
                  state_d = S_ON;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // events during a blink queue up, except on the gap's last cycle where
      // they are absorbed by the replay decision above
      if (event_in && (state_q != S_IDLE) && !off_term) begin
         if (pending == PEND_MAX) ovf_d = 1'b1;
         else                     pend_d = pending + PEND_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         led_out  <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         led_out  <= (state_d == S_ON);
         busy     <= (state_d != S_IDLE);
         pending  <= pend_d;
         overflow <= ovf_d;
      end
   end

endmodule

// File: tb/tb_led_event_blinker.sv
// Testbench for led_event_blinker with small timing parameters. A behavioural
// model tracks each blink as a position within an on+off window plus a queue
// depth, and every cycle's outputs are compared against it.
module tb_led_event_blinker;

   localparam int ON_BITS  = 3;
   localparam int OFF_BITS = 2;
   localparam int PEND_W   = 2;
   localparam int ON_LEN   = 2 ** ON_BITS;
   localparam int OFF_LEN  = 2 ** OFF_BITS;
   localparam int PMAX     = 2 ** PEND_W - 1;

   logic              clk;
   logic              n_reset;
   logic              event_in;
   logic              led_out;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   bit m_active;
   int m_t;
   int m_pend;
   bit m_ovf;
   int m_blinks;

   // independent blink-length monitor
   bit prev_led;
   int run_len;

   led_event_blinker #(
      .ON_BITS (ON_BITS),
      .OFF_BITS(OFF_BITS),
      .PEND_W  (PEND_W)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .event_in(event_in),
      .led_out (led_out),
      .busy    (busy),
      .pending (pending),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_edge(input bit ev, input bit rst_n);
      int q;
      if (!rst_n) begin
         m_active = 0;
         m_t      = 0;
         m_pend   = 0;
         m_ovf    = 0;
      end else if (!m_active) begin
         if (ev) begin
            m_active = 1;
            m_t      = 0;
            m_blinks++;
         end
      end else if (m_t == ON_LEN + OFF_LEN - 1) begin
         q = m_pend + (ev ? 1 : 0);
         if (q > 0) begin
            m_t    = 0;
            m_pend = q - 1;
            m_blinks++;
         end else begin
            m_active = 0;
         end
      end else begin
         m_t++;
         if (ev) begin
            if (m_pend == PMAX) m_ovf = 1;
            else                m_pend++;
         end
      end
   endtask

   task automatic step(input bit ev, input bit rst_n);
      bit exp_led;
      @(negedge clk);
      event_in = ev;
      n_reset  = rst_n;
      @(posedge clk);
      model_edge(ev, rst_n);
      #1;
      exp_led = m_active && (m_t < ON_LEN);

      vectors++;
      assert (led_out === exp_led) else begin
         miscompares++;
         $error("FAIL led_out: got %b expected %b", led_out, exp_led);
      end
      vectors++;
      assert (busy === m_active) else begin
         miscompares++;
         $error("FAIL busy: got %b expected %b", busy, m_active);
      end
      vectors++;
      assert (pending === PEND_W'(m_pend)) else begin
         miscompares++;
         $error("FAIL pending: got %0d expected %0d", pending, m_pend);
      end
      vectors++;
      assert (overflow === m_ovf) else begin
         miscompares++;
         $error("FAIL overflow: got %b expected %b", overflow, m_ovf);
      end

      if (!rst_n) begin
         run_len = 0;
      end else if (led_out === 1'b1) begin
         run_len++;
      end else if (prev_led) begin
         vectors++;
         assert (run_len == ON_LEN) else begin
            miscompares++;
            $error("FAIL on_time: got %0d cycles expected %0d", run_len, ON_LEN);
         end
         run_len = 0;
      end
      prev_led = (led_out === 1'b1);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   initial begin
      n_reset  = 1'b0;
      event_in = 1'b0;
      m_blinks = 0;
      prev_led = 0;
      run_len  = 0;

      // reset held with event toggling
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      idle_steps(6);
      vectors++;
      assert (m_blinks == 0 && led_out === 1'b0) else begin
         miscompares++;
         $error("FAIL reset_no_blink: led %b blinks %0d expected 0", led_out, m_blinks);
      end

      // single event
      step(1'b1, 1'b1);
      idle_steps(16);

      // three back-to-back events
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      idle_steps(40);

      // five events: saturation and overflow
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      idle_steps(55);

      // clear overflow, then coincident event on gap's final cycle
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      idle_steps(10);
      step(1'b1, 1'b1);
      idle_steps(30);

      // event on final gap cycle with nothing queued
      step(1'b1, 1'b1);
      idle_steps(11);
      step(1'b1, 1'b1);
      idle_steps(16);

      // saturated queue plus event on final gap cycle: no overflow
      step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      idle_steps(8);
      step(1'b1, 1'b1);
      idle_steps(60);

      // reset mid-blink with two queued
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      idle_steps(30);

      // randomized traffic with varying event density and rare resets
      for (int i = 0; i < 3000; i++) begin
         int dens;
         dens = (i / 500) % 3;
         step(($urandom_range(0, 9) < (dens == 0 ? 1 : (dens == 1 ? 3 : 7))),
              ($urandom_range(0, 299) != 0));
      end
      idle_steps(80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
